// File: rtl/box_anim_ctrl_pkg.sv
// Shared types and constants for the bouncing-box animation sequencer.
package box_anim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    WAIT,
    ERASE,
    UPDATE
  } state_e;

  localparam int          BOX_SIZE = 4;
  localparam logic [2:0]  BLACK    = 3'b000;
  localparam int          X_W      = 8;
  localparam int          Y_W      = 7;

endpackage

// File: rtl/box_anim_ctrl_if.sv
// Pixel write port from the animation sequencer to the VGA adapter.
interface box_anim_ctrl_if;
  import box_anim_pkg::*;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     color;
  logic           plot;

  modport master (output x, output y, output color, output plot);
  modport slave  (input  x, input  y, input  color, input  plot);
endinterface

// File: rtl/box_anim_ctrl_frame_timer.sv
// Frame delay and frame counters; counts only while en is high, zeroed by clr.
module frame_timer #(
  parameter int unsigned DELAY_CYCLES    = 833334,
  parameter int unsigned FRAMES_PER_MOVE = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic frame_tick,
  output logic move_due
);

  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int FW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
  localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_MOVE - 1);

  logic [DW-1:0] delay_cnt_q, delay_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;

  assign frame_tick = en && (delay_cnt_q == DELAY_LAST);
  assign move_due   = frame_tick && (frame_cnt_q == FRAME_LAST);

  always_comb begin
    delay_cnt_d = delay_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (clr) begin
      delay_cnt_d = '0;
      frame_cnt_d = '0;
    end else if (en) begin
      if (frame_tick) begin
        delay_cnt_d = '0;
        frame_cnt_d = move_due ? '0 : frame_cnt_q + FW'(1);
      end else begin
        delay_cnt_d = delay_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      delay_cnt_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      delay_cnt_q <= delay_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: rtl/box_anim_ctrl.sv
// Bouncing-box animation sequencer: draw, wait, erase, move, one pixel per cycle.
// Optional: define BOX_ANIM_COLOR_CYCLE_EN to advance the colour on every bounce.
module box_anim_ctrl
  import box_anim_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES    = 833334,
  parameter int unsigned FRAMES_PER_MOVE = 15,
  parameter int unsigned X_MAX           = 160,
  parameter int unsigned Y_MAX           = 120,
  parameter int unsigned Y_START         = 60
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   go,
  input  logic                   stop,
  input  logic [2:0]             color_in,
  box_anim_ctrl_if.master        pix,
  output logic                   busy,
  output logic                   frame_tick
);

  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX - BOX_SIZE);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX - BOX_SIZE);

  state_e         state_q, state_d;
  logic [3:0]     pix_cnt_q, pix_cnt_d;
  logic [X_W-1:0] x_pos_q, x_pos_d;
  logic [Y_W-1:0] y_pos_q, y_pos_d;
  logic           dir_x_q, dir_x_d;
  logic           dir_y_q, dir_y_d;
  logic [2:0]     color_q, color_d;
  logic           timer_clr, timer_en, move_due;
  logic           bounce_x, bounce_y;

  frame_timer #(
    .DELAY_CYCLES    (DELAY_CYCLES),
    .FRAMES_PER_MOVE (FRAMES_PER_MOVE)
  ) u_frame_timer (
    .clock      (clock),
    .reset      (reset),
    .clr        (timer_clr),
    .en         (timer_en),
    .frame_tick (frame_tick),
    .move_due   (move_due)
  );

  // Counters run only in WAIT, so every WAIT starts from zero.
  assign timer_en  = (state_q == WAIT);
  assign timer_clr = (state_q != WAIT);

  assign bounce_x = dir_x_q ? (x_pos_q == X_LIM) : (x_pos_q == '0);
  assign bounce_y = dir_y_q ? (y_pos_q == Y_LIM) : (y_pos_q == '0);

  assign pix.x = x_pos_q + {{(X_W-2){1'b0}}, pix_cnt_q[1:0]};
  assign pix.y = y_pos_q + {{(Y_W-2){1'b0}}, pix_cnt_q[3:2]};

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    x_pos_d   = x_pos_q;
    y_pos_d   = y_pos_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    color_d   = color_q;
    pix.plot  = 1'b0;
    pix.color = BLACK;
    busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (go) begin
          color_d   = color_in;
          pix_cnt_d = '0;
          state_d   = DRAW;
        end
      end
      DRAW: begin
        pix.plot  = 1'b1;
        pix.color = color_q;
        pix_cnt_d = pix_cnt_q + 4'd1;
        if (pix_cnt_q == 4'hF) begin
          pix_cnt_d = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (move_due) begin
          pix_cnt_d = '0;
          state_d   = ERASE;
        end
      end
      ERASE: begin
        pix.plot  = 1'b1;
        pix.color = BLACK;
        pix_cnt_d = pix_cnt_q + 4'd1;
        if (pix_cnt_q == 4'hF) begin
          pix_cnt_d = '0;
          state_d   = stop ? IDLE : UPDATE;
        end
      end
      UPDATE: begin
        // A bounce reverses direction and steps one pixel back in the same cycle.
        if (bounce_x) begin
          dir_x_d = ~dir_x_q;
          x_pos_d = dir_x_q ? x_pos_q - 8'd1 : 8'd1;
        end else begin
          x_pos_d = dir_x_q ? x_pos_q + 8'd1 : x_pos_q - 8'd1;
        end
        if (bounce_y) begin
          dir_y_d = ~dir_y_q;
          y_pos_d = dir_y_q ? y_pos_q - 7'd1 : 7'd1;
        end else begin
          y_pos_d = dir_y_q ? y_pos_q + 7'd1 : y_pos_q - 7'd1;
        end
`ifdef BOX_ANIM_COLOR_CYCLE_EN
        if (bounce_x || bounce_y) begin
          color_d = (color_q == 3'b111) ? 3'b001 : color_q + 3'd1;
        end
`endif
        pix_cnt_d = '0;
        state_d   = DRAW;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      x_pos_q   <= '0;
      y_pos_q   <= Y_W'(Y_START);
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b0;
      color_q   <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      x_pos_q   <= x_pos_d;
      y_pos_q   <= y_pos_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      color_q   <= color_d;
    end
  end

endmodule

// File: tb/tb_box_anim_ctrl.sv
// Directed bench for box_anim_ctrl with DELAY_CYCLES=4, FRAMES_PER_MOVE=2.
module tb_box_anim_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] color_in = 3'b101;
  logic       busy, frame_tick;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  box_anim_ctrl_if pix ();

  box_anim_ctrl #(
    .DELAY_CYCLES    (4),
    .FRAMES_PER_MOVE (2),
    .X_MAX           (160),
    .Y_MAX           (120),
    .Y_START         (60)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .stop       (stop),
    .color_in   (color_in),
    .pix        (pix.master),
    .busy       (busy),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pix(input string tag, input logic pl, input logic [2:0] col,
                         input logic [7:0] ex, input logic [6:0] ey);
    chk({tag, " plot"},  32'(pix.plot),  32'(pl));
    chk({tag, " color"}, 32'(pix.color), 32'(col));
    chk({tag, " x"},     32'(pix.x),     32'(ex));
    chk({tag, " y"},     32'(pix.y),     32'(ey));
  endtask

  // Move-number checkpoints (position at first DRAW pixel after move m).
  int unsigned cp_m [8] = '{60, 61, 156, 157, 176, 177, 312, 313};
  int unsigned cp_x [8] = '{60, 61, 156, 155, 136, 135, 0,   1};
  int unsigned cp_y [8] = '{0,  1,  96,  97,  116, 115, 20,  21};
`ifdef BOX_ANIM_COLOR_CYCLE_EN
  int unsigned cp_c [8] = '{5,  6,  6,   7,   7,   1,   2,   3};
`else
  int unsigned cp_c [8] = '{5,  5,  5,   5,   5,   5,   5,   5};
`endif

  initial begin
    int unsigned ticks;
    int unsigned cp;
    logic        plot_seen;

    repeat (2) @(negedge clock);
    chk("reset plot",  32'(pix.plot),  0);
    chk("reset busy",  32'(busy),      0);
    chk("reset tick",  32'(frame_tick), 0);
    chk("reset color", 32'(pix.color), 0);
    chk("reset x",     32'(pix.x),     0);
    chk("reset y",     32'(pix.y),     60);

    reset = 1'b1;
    @(negedge clock);
    chk("idle plot", 32'(pix.plot), 0);

    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    chk("draw busy", 32'(busy), 1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clock);
      chk_pix("draw0", 1'b1, 3'b101, 8'(i % 4), 7'(60 + i / 4));
    end

    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("wait plot", 32'(pix.plot), 0);
      chk("wait tick", 32'(frame_tick), 32'((i == 3) || (i == 7)));
      if (frame_tick) ticks++;
    end
    chk("wait tick count", ticks, 2);

    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk_pix("erase0", 1'b1, 3'b000, 8'(i % 4), 7'(60 + i / 4));
    end

    @(negedge clock);
    chk("update plot", 32'(pix.plot), 0);
    chk("update busy", 32'(busy), 1);

    @(negedge clock);
    chk_pix("move1", 1'b1, 3'b101, 8'd1, 7'd59);

    // Walk move by move (41-cycle period) through both bounces on each axis.
    cp = 0;
    for (int m = 2; m <= 313; m++) begin
      repeat (41) @(negedge clock);
      if (cp < 8 && cp_m[cp] == m) begin
        chk_pix($sformatf("move%0d", m), 1'b1, 3'(cp_c[cp]), 8'(cp_x[cp]), 7'(cp_y[cp]));
        cp++;
      end
    end

    // stop (and a stray go) raised during WAIT.
    repeat (16) @(negedge clock);
    stop = 1'b1;
    go   = 1'b1;
    plot_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      if (pix.plot) plot_seen = 1'b1;
    end
    chk("stop wait plot", 32'(plot_seen), 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk_pix("stop erase", 1'b1, 3'b000, 8'(1 + i % 4), 7'(21 + i / 4));
    end
    go = 1'b0;
    @(negedge clock);
    chk("stop idle busy", 32'(busy), 0);
    chk("stop idle plot", 32'(pix.plot), 0);
    plot_seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (pix.plot || busy) plot_seen = 1'b1;
    end
    chk("idle stays quiet", 32'(plot_seen), 0);
    stop = 1'b0;

    // Restart from the held position with a new colour, then reset mid-DRAW.
    color_in = 3'b011;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    chk_pix("restart p0", 1'b1, 3'b011, 8'd1, 7'd21);
    repeat (7) @(negedge clock);
    chk_pix("restart p7", 1'b1, 3'b011, 8'd4, 7'd22);
    #2 reset = 1'b0;
    #1;
    chk("midreset plot",  32'(pix.plot),  0);
    chk("midreset busy",  32'(busy),      0);
    chk("midreset color", 32'(pix.color), 0);
    chk("midreset x",     32'(pix.x),     0);
    chk("midreset y",     32'(pix.y),     60);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
